// File: rtl/pkt_rx_parser.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_rx_parser
//  Purpose  : Receive front-end for the node routing core. Assembles a
//             byte-serial routing header into five 16-bit fields. It then
//             verifies the 8-bit additive checksum, drops frames that this
//             node sourced itself, and starts the core with node_en. After a
//             dispatch it accepts no input until the core reports node_done.
//
//  Ports    : clock, nrst          - rising-edge clock, async active-low reset
//             my_node_id           - own ID for the self-source filter
//             rx_valid/rx_sop/     - byte stream in; a byte is taken when
//             rx_byte/rx_ready       rx_valid && rx_ready
//             f_source_id ..       - field outputs to the core; they change
//             f_value                only when a packet is dispatched
//             node_en / node_done  - core start level / core completion
//             err_pulse            - 1-cycle flag: bad checksum, resync, gap
//             pkt_cnt/err_cnt/     - saturating event counters
//             drop_cnt
//
//  Revision : 1.0 - initial release
// ============================================================================
module pkt_rx_parser #(
    parameter int WORD_WIDTH  = 16,
    parameter int HDR_BYTES   = 10,
    parameter int GAP_TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic [WORD_WIDTH-1:0] my_node_id,
    input  logic                  rx_valid,
    input  logic                  rx_sop,
    input  logic [7:0]            rx_byte,
    output logic                  rx_ready,
    output logic [WORD_WIDTH-1:0] f_source_id,
    output logic [WORD_WIDTH-1:0] f_destination_id,
    output logic [WORD_WIDTH-1:0] f_cluster_id,
    output logic [WORD_WIDTH-1:0] f_battery_stat,
    output logic [WORD_WIDTH-1:0] f_value,
    output logic                  node_en,
    input  logic                  node_done,
    output logic                  err_pulse,
    output logic [WORD_WIDTH-1:0] pkt_cnt,
    output logic [WORD_WIDTH-1:0] err_cnt,
    output logic [WORD_WIDTH-1:0] drop_cnt
);

    localparam int IDX_W     = $clog2(HDR_BYTES + 1);
    localparam int C_NFIELDS = HDR_BYTES / 2;

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_HDR      = 2'd1;
    localparam logic [1:0] c_CHK      = 2'd2;
    localparam logic [1:0] c_DISPATCH = 2'd3;

    // Index value at which the incoming byte is the checksum, not payload.
    localparam logic [IDX_W-1:0]      c_CHK_IDX  = IDX_W'(HDR_BYTES);
    localparam logic [IDX_W-1:0]      c_IDX_ONE  = IDX_W'(1);
    localparam logic [WORD_WIDTH-1:0] c_GAP_LAST = WORD_WIDTH'(GAP_TIMEOUT - 1);
    localparam logic [WORD_WIDTH-1:0] c_CNT_MAX  = {WORD_WIDTH{1'b1}};

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;

    logic [7:0]            r_buf [HDR_BYTES];
    logic [7:0]            r_sum;
    logic [7:0]            r_chk;
    logic [IDX_W-1:0]      r_idx;
    logic [WORD_WIDTH-1:0] r_gap;
    logic [WORD_WIDTH-1:0] r_field [C_NFIELDS];
    logic                  r_node_en;
    logic                  r_err_pulse;
    logic [WORD_WIDTH-1:0] r_pkt_cnt;
    logic [WORD_WIDTH-1:0] r_err_cnt;
    logic [WORD_WIDTH-1:0] r_drop_cnt;

    logic [WORD_WIDTH-1:0] w_field [C_NFIELDS];
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_resync;
    logic                  w_timeout;
    logic                  w_sum_bad;
    logic                  w_self;
    logic                  w_dispatch;
    logic                  w_done;
    logic                  w_err;

    function automatic logic [WORD_WIDTH-1:0] sat_inc(input logic [WORD_WIDTH-1:0] v);
        return (v == c_CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Big-endian field view of the shadow buffer.
    generate
        for (genvar k = 0; k < C_NFIELDS; k++) begin : g_field
            assign w_field[k] = WORD_WIDTH'({r_buf[2*k], r_buf[2*k+1]});
        end
    endgenerate

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept && rx_sop) begin
                    w_state_nxt = c_HDR;
                end
            end
            c_HDR: begin
                // An accepted byte always beats a simultaneous gap timeout.
                if (w_accept) begin
                    if (!rx_sop && (r_idx == c_CHK_IDX)) begin
                        w_state_nxt = c_CHK;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_CHK: begin
                w_state_nxt = w_dispatch ? c_DISPATCH : c_IDLE;
            end
            c_DISPATCH: begin
                if (w_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------- outputs / event decode
    always_comb begin
        w_ready    = (r_state == c_IDLE) || (r_state == c_HDR);
        w_accept   = rx_valid && w_ready;
        w_resync   = (r_state == c_HDR) && w_accept && rx_sop;
        w_timeout  = (r_state == c_HDR) && !w_accept && (r_gap == c_GAP_LAST);
        w_sum_bad  = (r_state == c_CHK) && (r_sum != r_chk);
        w_self     = (r_state == c_CHK) && !w_sum_bad && (w_field[0] == my_node_id);
        w_dispatch = (r_state == c_CHK) && !w_sum_bad && !w_self;
        w_done     = (r_state == c_DISPATCH) && node_done;
        w_err      = w_resync || w_timeout || w_sum_bad;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < HDR_BYTES; i++) begin
                r_buf[i] <= '0;
            end
            for (int k = 0; k < C_NFIELDS; k++) begin
                r_field[k] <= '0;
            end
            r_sum       <= '0;
            r_chk       <= '0;
            r_idx       <= '0;
            r_gap       <= '0;
            r_node_en   <= 1'b0;
            r_err_pulse <= 1'b0;
            r_pkt_cnt   <= '0;
            r_err_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            // Byte capture. An SOP byte always restarts the frame at byte 0,
            // both from IDLE and as a resync inside HDR.
            if (w_accept) begin
                r_gap <= '0;
                if (rx_sop) begin
                    r_buf[0] <= rx_byte;
                    r_sum    <= rx_byte;
                    r_idx    <= c_IDX_ONE;
                end else if (r_state == c_HDR) begin
                    if (r_idx == c_CHK_IDX) begin
                        r_chk <= rx_byte;
                    end else begin
                        r_buf[r_idx] <= rx_byte;
                        r_sum        <= r_sum + rx_byte;
                    end
                    r_idx <= r_idx + 1'b1;
                end
            end else if ((r_state == c_HDR) && !w_timeout) begin
                r_gap <= r_gap + 1'b1;
            end else begin
                r_gap <= '0;
            end

            r_err_pulse <= w_err;
            if (w_err) begin
                r_err_cnt <= sat_inc(r_err_cnt);
            end
            if (w_self) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end

            if (w_dispatch) begin
                for (int k = 0; k < C_NFIELDS; k++) begin
                    r_field[k] <= w_field[k];
                end
                r_node_en <= 1'b1;
                r_pkt_cnt <= sat_inc(r_pkt_cnt);
            end else if (w_done) begin
                r_node_en <= 1'b0;
            end
        end
    end

    assign rx_ready         = w_ready;
    assign f_source_id      = r_field[0];
    assign f_destination_id = r_field[1];
    assign f_cluster_id     = r_field[2];
    assign f_battery_stat   = r_field[3];
    assign f_value          = r_field[4];
    assign node_en          = r_node_en;
    assign err_pulse        = r_err_pulse;
    assign pkt_cnt          = r_pkt_cnt;
    assign err_cnt          = r_err_cnt;
    assign drop_cnt         = r_drop_cnt;

endmodule
`default_nettype wire
